// File: rtl/tiny_core_pkg.sv
// Shared definitions for the tiny core: instruction format, ALU opcodes,
// the special HALT/NOP words and the issue unit state encoding.
package tiny_core_pkg;

    localparam int INSTR_W = 32;

    // Instruction field bit positions
    localparam int DEST_MSB   = 31;
    localparam int DEST_LSB   = 25;
    localparam int SRC1_MSB   = 24;
    localparam int SRC1_LSB   = 18;
    localparam int SRC2_MSB   = 17;
    localparam int SRC2_LSB   = 11;
    localparam int OPCODE_MSB = 2;
    localparam int OPCODE_LSB = 0;

    // ALU opcodes carried in the low three bits
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    // Program terminator (never issued) and the idle filler word
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } issue_state_t;

    // True when a fetched word terminates the program
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/instruction_issue_unit_if.sv
// Load/control inputs and issue outputs of the instruction issue unit.
// The master drives program loads, start and stall; the slave is the unit.
interface instruction_issue_unit_if #(
    parameter int ADDR_W = 4
);
    logic              load_enable_in;
    logic [ADDR_W-1:0] load_address_in;
    logic [31:0]       load_data_in;
    logic              start_in;
    logic              stall_in;
    logic [31:0]       current_instruction_out;
    logic              instruction_valid_out;
    logic [ADDR_W-1:0] program_counter_out;
    logic              busy_out;
    logic              done_out;

    modport master (
        output load_enable_in,
        output load_address_in,
        output load_data_in,
        output start_in,
        output stall_in,
        input  current_instruction_out,
        input  instruction_valid_out,
        input  program_counter_out,
        input  busy_out,
        input  done_out
    );

    modport slave (
        input  load_enable_in,
        input  load_address_in,
        input  load_data_in,
        input  start_in,
        input  stall_in,
        output current_instruction_out,
        output instruction_valid_out,
        output program_counter_out,
        output busy_out,
        output done_out
    );

endinterface

// File: rtl/instruction_memory.sv
// Local program store: one synchronous write port and a combinational read
// port. The read data is registered downstream by the issue register, so a
// word written on one edge is visible to a fetch on the following edge.
// Contents are deliberately not reset.
module instruction_memory
    import tiny_core_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clock_in,
    input  logic               write_enable,
    input  logic [ADDR_W-1:0]  write_address,
    input  logic [INSTR_W-1:0] write_data,
    input  logic [ADDR_W-1:0]  read_address,
    output logic [INSTR_W-1:0] read_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Store a program word on the rising edge when a write is requested
    always_ff @(posedge clock_in) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/instruction_issue_unit.sv
// Instruction issue unit: holds a small program, and once started walks the
// program counter from 0, issuing one word per unstalled cycle until a HALT
// word is fetched or the last memory location has been issued.
module instruction_issue_unit
    import tiny_core_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clock_in,
    input  logic                      reset_n_in,
    instruction_issue_unit_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    issue_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] fetch_word;
    logic               mem_write;

    // Program loads are only accepted while no program is running
    assign mem_write = bus.load_enable_in && (state_q != RUN);

    instruction_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_memory (
        .clock_in      (clock_in),
        .write_enable  (mem_write),
        .write_address (bus.load_address_in),
        .write_data    (bus.load_data_in),
        .read_address  (pc_q),
        .read_data     (fetch_word)
    );

    // State, program counter and issue register, cleared immediately on reset
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: start handling, sequencing, stall hold and termination
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        case (state_q)
            IDLE, DONE: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (bus.start_in) begin
                    pc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.stall_in) begin
                    if (is_halt(fetch_word)) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        instr_d = fetch_word;
                        valid_d = 1'b1;
                        if (pc_q == LAST_ADDR) begin
                            state_d = DONE;
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.current_instruction_out = instr_q;
    assign bus.instruction_valid_out   = valid_q;
    assign bus.program_counter_out     = pc_q;
    assign bus.busy_out                = (state_q == RUN);
    assign bus.done_out                = (state_q == DONE);

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Testbench for instruction_issue_unit (DEPTH=4): directed scenarios plus
// randomized programs checked against a program-level reference model.
module tb_instruction_issue_unit;
    import tiny_core_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] basic_prog [4];

    instruction_issue_unit_if #(.ADDR_W(AW)) bus ();

    instruction_issue_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [AW-1:0] addr, input logic [31:0] data);
        bus.load_enable_in  = 1'b1;
        bus.load_address_in = addr;
        bus.load_data_in    = data;
        tick();
        bus.load_enable_in  = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        bit reached;
        reached = 0;
        for (int c = 0; c < 40 && !reached; c++) begin
            if (bus.done_out === 1'b1 && bus.instruction_valid_out === 1'b0) reached = 1;
            else tick();
        end
        total++;
        if (!reached) begin
            bad++;
            $display("[TB] FAIL %s_timeout got=not_done exp=done", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (bus.current_instruction_out !== NOP_WORD) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=%h", bus.current_instruction_out, NOP_WORD); end
        total++; if (bus.instruction_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.instruction_valid_out); end
        total++; if (bus.program_counter_out !== 2'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0d exp=0", bus.program_counter_out); end
        total++; if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_done got=%b%b exp=00", bus.busy_out, bus.done_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (bus.busy_out !== 1'b0 || bus.instruction_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset got=busy%b valid%b exp=busy0 valid0", bus.busy_out, bus.instruction_valid_out); end
    endtask

    task automatic test_basic_program();
        for (int a = 0; a < 4; a++) load_word(AW'(a), basic_prog[a]);
        pulse_start();
        total++; if (bus.busy_out !== 1'b1 || bus.instruction_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL basic_start got=busy%b valid%b exp=busy1 valid0", bus.busy_out, bus.instruction_valid_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.instruction_valid_out !== 1'b1 || bus.current_instruction_out !== basic_prog[i]) begin bad++; $display("[TB] FAIL basic_issue[%0d] got=%b/%h exp=1/%h", i, bus.instruction_valid_out, bus.current_instruction_out, basic_prog[i]); end
            total++; if (bus.program_counter_out !== AW'(i + 1)) begin bad++; $display("[TB] FAIL basic_pc[%0d] got=%0d exp=%0d", i, bus.program_counter_out, i + 1); end
        end
        tick();
        total++; if (bus.instruction_valid_out !== 1'b0 || bus.current_instruction_out !== NOP_WORD) begin bad++; $display("[TB] FAIL basic_end_out got=%b/%h exp=0/%h", bus.instruction_valid_out, bus.current_instruction_out, NOP_WORD); end
        total++; if (bus.done_out !== 1'b1 || bus.program_counter_out !== 2'd3) begin bad++; $display("[TB] FAIL basic_end_state got=done%b pc%0d exp=done1 pc3", bus.done_out, bus.program_counter_out); end
    endtask

    task automatic test_stall();
        pulse_start();
        tick();
        total++; if (bus.current_instruction_out !== basic_prog[0]) begin bad++; $display("[TB] FAIL stall_w0 got=%h exp=%h", bus.current_instruction_out, basic_prog[0]); end
        tick();
        bus.stall_in = 1'b1;
        for (int s = 0; s < 2; s++) begin
            tick();
            total++; if (bus.current_instruction_out !== basic_prog[1] || bus.instruction_valid_out !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold[%0d] got=%b/%h exp=1/%h", s, bus.instruction_valid_out, bus.current_instruction_out, basic_prog[1]); end
            total++; if (bus.program_counter_out !== 2'd2) begin bad++; $display("[TB] FAIL stall_pc[%0d] got=%0d exp=2", s, bus.program_counter_out); end
        end
        bus.stall_in = 1'b0;
        tick();
        total++; if (bus.current_instruction_out !== basic_prog[2] || bus.done_out !== 1'b0) begin bad++; $display("[TB] FAIL stall_w2 got=%h done%b exp=%h done0", bus.current_instruction_out, bus.done_out, basic_prog[2]); end
        tick();
        total++; if (bus.done_out !== 1'b1 || bus.instruction_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL stall_length got=done%b valid%b exp=done1 valid0", bus.done_out, bus.instruction_valid_out); end
    endtask

    task automatic test_full_memory();
        for (int a = 0; a < 4; a++) load_word(AW'(a), 32'(a + 1));
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.instruction_valid_out !== 1'b1 || bus.current_instruction_out !== 32'(i + 1)) begin bad++; $display("[TB] FAIL full_issue[%0d] got=%b/%h exp=1/%h", i, bus.instruction_valid_out, bus.current_instruction_out, i + 1); end
        end
        total++; if (bus.done_out !== 1'b1 || bus.program_counter_out !== 2'd3) begin bad++; $display("[TB] FAIL full_last got=done%b pc%0d exp=done1 pc3", bus.done_out, bus.program_counter_out); end
        tick();
        total++; if (bus.instruction_valid_out !== 1'b0 || bus.current_instruction_out !== NOP_WORD || bus.program_counter_out !== 2'd3) begin bad++; $display("[TB] FAIL full_after got=%b/%h pc%0d exp=0/%h pc3", bus.instruction_valid_out, bus.current_instruction_out, bus.program_counter_out, NOP_WORD); end
    endtask

    task automatic test_load_during_run();
        pulse_start();
        bus.load_enable_in  = 1'b1;
        bus.load_address_in = 2'd2;
        bus.load_data_in    = 32'hDEAD_BEEF;
        tick();
        bus.load_enable_in  = 1'b0;
        tick();
        tick();
        total++; if (bus.current_instruction_out !== 32'd3) begin bad++; $display("[TB] FAIL run_load_ignored got=%h exp=%h", bus.current_instruction_out, 32'd3); end
        run_to_done("run_load");
        pulse_start();
        tick(); tick(); tick();
        total++; if (bus.current_instruction_out !== 32'd3) begin bad++; $display("[TB] FAIL restart_original got=%h exp=%h", bus.current_instruction_out, 32'd3); end
        run_to_done("restart_original");
        load_word(2'd2, 32'hDEAD_BEEF);
        pulse_start();
        tick(); tick(); tick();
        total++; if (bus.current_instruction_out !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL done_load got=%h exp=deadbeef", bus.current_instruction_out); end
        run_to_done("done_load");
    endtask

    task automatic test_async_reset();
        pulse_start();
        tick(); tick();
        total++; if (bus.current_instruction_out !== 32'd2) begin bad++; $display("[TB] FAIL areset_pre got=%h exp=%h", bus.current_instruction_out, 32'd2); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.current_instruction_out !== NOP_WORD || bus.instruction_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL areset_out got=%b/%h exp=0/%h", bus.instruction_valid_out, bus.current_instruction_out, NOP_WORD); end
        total++; if (bus.program_counter_out !== 2'd0 || bus.busy_out !== 1'b0) begin bad++; $display("[TB] FAIL areset_state got=pc%0d busy%b exp=pc0 busy0", bus.program_counter_out, bus.busy_out); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        tick();
        total++; if (bus.current_instruction_out !== 32'd1 || bus.instruction_valid_out !== 1'b1) begin bad++; $display("[TB] FAIL areset_restart_w0 got=%b/%h exp=1/%h", bus.instruction_valid_out, bus.current_instruction_out, 32'd1); end
        tick();
        total++; if (bus.current_instruction_out !== 32'd2) begin bad++; $display("[TB] FAIL areset_restart_w1 got=%h exp=%h", bus.current_instruction_out, 32'd2); end
        run_to_done("areset");
    endtask

    task automatic test_halt_first();
        load_word(2'd0, HALT_WORD);
        pulse_start();
        total++; if (bus.busy_out !== 1'b1 || bus.done_out !== 1'b0) begin bad++; $display("[TB] FAIL halt_run got=busy%b done%b exp=busy1 done0", bus.busy_out, bus.done_out); end
        tick();
        total++; if (bus.done_out !== 1'b1 || bus.program_counter_out !== 2'd0) begin bad++; $display("[TB] FAIL halt_done got=done%b pc%0d exp=done1 pc0", bus.done_out, bus.program_counter_out); end
        for (int c = 0; c < 3; c++) begin
            bus.stall_in = c[0];
            tick();
            total++; if (bus.instruction_valid_out !== 1'b0 || bus.current_instruction_out !== NOP_WORD) begin bad++; $display("[TB] FAIL halt_quiet[%0d] got=%b/%h exp=0/%h", c, bus.instruction_valid_out, bus.current_instruction_out, NOP_WORD); end
        end
        bus.stall_in = 1'b0;
    endtask

    task automatic test_load_with_start();
        bus.load_enable_in  = 1'b1;
        bus.load_address_in = 2'd0;
        bus.load_data_in    = 32'h1111_0001;
        bus.start_in        = 1'b1;
        tick();
        bus.load_enable_in  = 1'b0;
        bus.start_in        = 1'b0;
        tick();
        total++; if (bus.instruction_valid_out !== 1'b1 || bus.current_instruction_out !== 32'h1111_0001) begin bad++; $display("[TB] FAIL load_start_first got=%b/%h exp=1/11110001", bus.instruction_valid_out, bus.current_instruction_out); end
        run_to_done("load_start");
    endtask

    task automatic test_random();
        logic [31:0] prog [DEPTH];
        logic [31:0] exp_q [$];
        logic [31:0] prev_instr;
        logic        prev_valid;
        logic [AW-1:0] prev_pc;
        logic [AW-1:0] exp_pc;
        bit  halted, finished, stl, was_busy;
        int  halt_idx, exp_edges, edges;
        for (int it = 0; it < 40; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                prog[a] = ($urandom_range(0, 4) == 0) ? HALT_WORD : $urandom();
                load_word(AW'(a), prog[a]);
            end
            exp_q.delete();
            halted = 0;
            halt_idx = 0;
            for (int a = 0; a < DEPTH; a++) begin
                if (!halted) begin
                    if (prog[a] == HALT_WORD) begin
                        halted = 1;
                        halt_idx = a;
                    end else begin
                        exp_q.push_back(prog[a]);
                    end
                end
            end
            exp_pc    = halted ? AW'(halt_idx) : AW'(DEPTH - 1);
            exp_edges = halted ? halt_idx + 1 : DEPTH;
            pulse_start();
            edges = 0;
            finished = 0;
            for (int c = 0; c < 100 && !finished; c++) begin
                stl          = ($urandom_range(0, 2) == 0);
                bus.stall_in = stl;
                was_busy     = bus.busy_out;
                prev_instr   = bus.current_instruction_out;
                prev_valid   = bus.instruction_valid_out;
                prev_pc      = bus.program_counter_out;
                tick();
                if (was_busy && stl) begin
                    total++;
                    if (bus.current_instruction_out !== prev_instr || bus.instruction_valid_out !== prev_valid || bus.program_counter_out !== prev_pc || bus.busy_out !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL rand_stall[%0d] got=%b/%h pc%0d exp=%b/%h pc%0d", it, bus.instruction_valid_out, bus.current_instruction_out, bus.program_counter_out, prev_valid, prev_instr, prev_pc);
                    end
                end else if (was_busy) begin
                    edges++;
                    if (bus.instruction_valid_out === 1'b1) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("[TB] FAIL rand_extra[%0d] got=%h exp=none", it, bus.current_instruction_out);
                        end else if (bus.current_instruction_out !== exp_q[0]) begin
                            bad++;
                            $display("[TB] FAIL rand_word[%0d] got=%h exp=%h", it, bus.current_instruction_out, exp_q[0]);
                            void'(exp_q.pop_front());
                        end else begin
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (bus.instruction_valid_out !== 1'b1) begin
                    total++;
                    if (bus.current_instruction_out !== NOP_WORD) begin bad++; $display("[TB] FAIL rand_nop[%0d] got=%h exp=%h", it, bus.current_instruction_out, NOP_WORD); end
                end
                if (bus.done_out === 1'b1 && bus.instruction_valid_out === 1'b0) finished = 1;
            end
            bus.stall_in = 1'b0;
            total++; if (!finished) begin bad++; $display("[TB] FAIL rand_timeout[%0d] got=running exp=done", it); end
            total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rand_missing[%0d] got=%0d_left exp=0_left", it, exp_q.size()); end
            total++; if (bus.program_counter_out !== exp_pc) begin bad++; $display("[TB] FAIL rand_pc[%0d] got=%0d exp=%0d", it, bus.program_counter_out, exp_pc); end
            total++; if (edges != exp_edges) begin bad++; $display("[TB] FAIL rand_edges[%0d] got=%0d exp=%0d", it, edges, exp_edges); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        basic_prog[0] = 32'h0204_0801;
        basic_prog[1] = 32'h0408_1002;
        basic_prog[2] = 32'h0610_1803;
        basic_prog[3] = HALT_WORD;
        rst_n               = 1'b0;
        bus.load_enable_in  = 1'b0;
        bus.load_address_in = '0;
        bus.load_data_in    = '0;
        bus.start_in        = 1'b0;
        bus.stall_in        = 1'b0;

        $display("[TB] reset");
        test_reset();
        $display("[TB] basic program");
        test_basic_program();
        $display("[TB] stall");
        test_stall();
        $display("[TB] full memory");
        test_full_memory();
        $display("[TB] load during run");
        test_load_during_run();
        $display("[TB] async reset");
        test_async_reset();
        $display("[TB] halt first");
        test_halt_first();
        $display("[TB] load with start");
        test_load_with_start();
        $display("[TB] random programs");
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_issue_unit.md
Name: instruction_issue_unit

Overview:
- Producer side of the CPU's `current_instruction` input.
- Holds a small program in local instruction memory, loaded through a write port while idle.
- On start, sequences a program counter and issues one 32-bit instruction per cycle to the CPU, honouring a stall input.
- Terminates on a HALT word or at the end of memory; reports busy and done to the testbench/top level.

Parameters:
- DEPTH, 16, instruction memory depth in words (power of two, ≥ 2).
- ADDR_W, $clog2(DEPTH), program counter and load address width.

Ports:
- clock_in  input  1  system clock, all logic on its rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- load_enable_in  input  1  write load_data_in into memory at load_address_in.
- load_address_in  input  ADDR_W  load target word address.
- load_data_in  input  32  instruction word to store.
- start_in  input  1  begin execution from address 0.
- stall_in  input  1  hold the issued instruction and the PC.
- current_instruction_out  output  32  instruction to the CPU (fields: dest [31:25], src1 [24:18], src2 [17:11], opcode [2:0]).
- instruction_valid_out  output  1  current_instruction_out is a real program instruction this cycle.
- program_counter_out  output  ADDR_W  address of the next word to fetch.
- busy_out  output  1  state == RUN.
- done_out  output  1  state == DONE.

Behaviour:
Reset:
- Asserting reset_n_in low, at any time and including mid-run, immediately sets state=IDLE, PC=0, current_instruction_out=NOP_WORD, instruction_valid_out=0.
- busy_out and done_out are therefore 0 during reset.
- Memory contents are not reset.

States:
- IDLE: waiting for a program or a start.
- RUN: issuing instructions.
- DONE: finished. Outputs hold NOP_WORD with valid=0; PC holds its final value.

Load port:
- Synchronous write, accepted only in IDLE or DONE; ignored in RUN.
- Load and start in the same IDLE cycle: the write completes, and it is visible to the first fetch.

Start:
- start_in in IDLE or DONE at edge t: PC<=0, state<=RUN.
- start_in in RUN is ignored.

RUN, per edge with stall_in=0, with w = mem[PC]:
- If w == HALT_WORD: current_instruction_out<=NOP_WORD, valid<=0, state<=DONE, PC unchanged. The HALT word is never issued.
- Otherwise: current_instruction_out<=w, valid<=1, and then:
  - if PC == DEPTH-1: PC unchanged, state<=DONE; valid falls on the next edge;
  - else PC<=PC+1.

Latency:
- First instruction is valid at edge t+1 after start sampled at edge t.
- Thereafter one instruction per unstalled cycle.

Stall:
- stall_in=1 in RUN holds current_instruction_out, valid and PC unchanged.
- Stall has no effect in IDLE or DONE.
- Stall and HALT together: the stall wins; HALT is detected on the first unstalled edge.

General:
- No arithmetic beyond the PC increment. The PC never wraps; the end of memory forces DONE.
- Whenever valid=0, current_instruction_out = NOP_WORD.

Decomposition:
Shared package tiny_core_pkg:
- INSTR_W=32.
- Field bit positions (DEST_MSB/LSB 31:25, SRC1 24:18, SRC2 17:11, OPCODE 2:0).
- ALU opcode constants.
- HALT_WORD=32'hFFFF_FFFF.
- NOP_WORD=32'h0000_0000.
- issue_state_t enum {IDLE, RUN, DONE}.

Sub-module instruction_memory:
- DEPTH x 32, one synchronous write port plus a combinational read at PC; read is registered by the issue register.
- No reset of contents.

Test Plan:
1. Load 0:32'h0204_0801, 1:32'h0408_1002, 2:32'h0610_1803, 3:HALT_WORD; pulse start -> exactly three consecutive valid cycles carrying those words in order starting 1 edge after start; then valid=0, output=NOP_WORD, done_out=1, program_counter_out=3.
2. Same program; hold stall_in high for 2 cycles while word 1 is issued -> word 1 is visible for 3 cycles; PC holds at 2; total run length grows by exactly 2 cycles.
3. DEPTH=4, all four words non-HALT (1,2,3,4) -> four valid cycles issuing 1,2,3,4; then done_out=1 and program_counter_out=3.
4. During RUN, assert load_enable_in at address 2 with 32'hDEAD_BEEF -> the issued word at address 2 is the original; after DONE, restart shows the original too; a load in DONE then restart shows DEAD_BEEF.
5. Pull reset_n_in low asynchronously between edges while word 1 is valid -> outputs go to NOP_WORD, valid=0, PC=0 and busy_out=0 before the next edge; after release, start reissues from word 0 with memory intact.
6. HALT_WORD at address 0, then start -> no valid cycle ever; done_out=1 one edge after RUN is entered; PC=0.
